// File: rtl/jtag_uart_bridge.sv
// ============================================================================
// jtag_uart_bridge
// ----------------------------------------------------------------------------
// Purpose:
//   Masters an Avalon-MM JTAG UART core and exposes two byte streams to the
//   CPU. A TX FIFO buffers CPU->host bytes and an RX FIFO buffers host->CPU
//   bytes. TX writes are batched against a WSPACE credit counter, so a single
//   control-register read can be followed by several data writes. A
//   round-robin arbiter alternates between RX polling and TX draining.
//
// Parameters:
//   TX_LOG_DEPTH   log2 of the TX FIFO depth
//   RX_LOG_DEPTH   log2 of the RX FIFO depth
//
// Ports:
//   clock, reset           single clock, asynchronous active-high reset
//   address                Avalon byte address (0 = data, 4 = control)
//   writedata, write       Avalon write data / strobe
//   read                   Avalon read strobe
//   waitrequest, readdata  Avalon stall / read data
//   in_canGet, in_getData  CPU->host byte source
//   in_get                 byte taken from in_getData this cycle
//   out_canGet             RX FIFO not empty
//   out_getData            RX FIFO head byte
//   out_get                CPU pops the RX head (ignored when empty)
//
// Optional feature (macro JTAG_UART_BRIDGE_STATS_EN):
//   Adds tx_count / rx_count outputs counting completed TX writes and RX
//   pushes. Both wrap at 2^32. Without the macro these ports do not exist.
// ============================================================================
module jtag_uart_bridge #(
    parameter int TX_LOG_DEPTH = 4,
    parameter int RX_LOG_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    output logic [2:0]  address,
    output logic [31:0] writedata,
    output logic        write,
    output logic        read,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    input  logic        in_canGet,
    input  logic [7:0]  in_getData,
    output logic        in_get,
    output logic        out_canGet,
    output logic [7:0]  out_getData,
    input  logic        out_get
`ifdef JTAG_UART_BRIDGE_STATS_EN
    ,
    output logic [31:0] tx_count,
    output logic [31:0] rx_count
`endif
);

    localparam int TX_DEPTH = 1 << TX_LOG_DEPTH;
    localparam int RX_DEPTH = 1 << RX_LOG_DEPTH;
    localparam logic [TX_LOG_DEPTH:0] TX_FULL_LEVEL = (TX_LOG_DEPTH+1)'(TX_DEPTH);
    localparam logic [TX_LOG_DEPTH:0] TX_ONE        = (TX_LOG_DEPTH+1)'(1);
    localparam logic [RX_LOG_DEPTH:0] RX_FULL_LEVEL = (RX_LOG_DEPTH+1)'(RX_DEPTH);

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_CTRL = 3'd4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RX_RD  = 2'd1,
        TX_CHK = 2'd2,
        TX_WR  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // TX FIFO (CPU -> host)
    // ------------------------------------------------------------------
    logic [7:0]              tx_mem [TX_DEPTH];
    logic [TX_LOG_DEPTH-1:0] tx_wr_ptr_reg;
    logic [TX_LOG_DEPTH-1:0] tx_rd_ptr_reg;
    logic [TX_LOG_DEPTH-1:0] tx_rd_ptr_inc;
    logic [TX_LOG_DEPTH:0]   tx_level_reg;
    logic                    tx_full;
    logic                    tx_empty;
    logic                    tx_push;
    logic                    tx_pop;
    logic [7:0]              tx_head;
    logic [7:0]              tx_next_head;

    // ------------------------------------------------------------------
    // RX FIFO (host -> CPU)
    // ------------------------------------------------------------------
    logic [7:0]              rx_mem [RX_DEPTH];
    logic [RX_LOG_DEPTH-1:0] rx_wr_ptr_reg;
    logic [RX_LOG_DEPTH-1:0] rx_rd_ptr_reg;
    logic [RX_LOG_DEPTH:0]   rx_level_reg;
    logic                    rx_full;
    logic                    rx_push;
    logic                    rx_pop;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_t      state_reg;
    logic [15:0] wcred_reg;
    logic        last_tx_reg;   // 1 = TX was the last service granted
    logic [2:0]  burst_reg;     // writes already completed in this TX burst

    logic rx_ok;
    logic tx_ok;
    logic pick_rx;
    logic continue_burst;
    logic xfer_done;

    // Bits of readdata the bridge never looks at.
    logic unused_readdata;
    assign unused_readdata = ^readdata[14:8];

    assign tx_full      = (tx_level_reg == TX_FULL_LEVEL);
    assign tx_empty     = (tx_level_reg == '0);
    assign in_get       = in_canGet & ~tx_full & ~reset;
    assign tx_push      = in_get;
    assign xfer_done    = ~waitrequest;
    assign tx_pop       = (state_reg == TX_WR) & write & xfer_done;
    assign tx_rd_ptr_inc = tx_rd_ptr_reg + 1'b1;
    assign tx_head      = tx_mem[tx_rd_ptr_reg];
    assign tx_next_head = tx_mem[tx_rd_ptr_inc];

    assign rx_full      = (rx_level_reg == RX_FULL_LEVEL);
    assign out_canGet   = (rx_level_reg != '0);
    assign out_getData  = rx_mem[rx_rd_ptr_reg];
    assign rx_pop       = out_get & out_canGet;
    assign rx_push      = (state_reg == RX_RD) & read & xfer_done & readdata[15];

    // Arbitration: when both services are ready, the one not granted last
    // time wins.
    assign rx_ok   = ~rx_full;
    assign tx_ok   = ~tx_empty;
    assign pick_rx = rx_ok & (~tx_ok | last_tx_reg);

    // Keep writing only while another byte is already queued, at least one
    // credit survives this write, and the burst has not reached 8 writes.
    // A byte pushed during this cycle is deliberately not counted.
    assign continue_burst = (tx_level_reg > TX_ONE) && (wcred_reg != 16'd1)
                            && (burst_reg != 3'd7);

    // ------------------------------------------------------------------
    // FIFO storage (no reset on the arrays themselves)
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr_reg] <= in_getData;
        end
        if (rx_push) begin
            rx_mem[rx_wr_ptr_reg] <= readdata[7:0];
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers and levels
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_wr_ptr_reg <= '0;
            tx_rd_ptr_reg <= '0;
            tx_level_reg  <= '0;
            rx_wr_ptr_reg <= '0;
            rx_rd_ptr_reg <= '0;
            rx_level_reg  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + 1'b1;
            if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_inc;
            if (tx_push && !tx_pop)      tx_level_reg <= tx_level_reg + 1'b1;
            else if (!tx_push && tx_pop) tx_level_reg <= tx_level_reg - 1'b1;

            if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
            if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
            if (rx_push && !rx_pop)      rx_level_reg <= rx_level_reg + 1'b1;
            else if (!rx_push && rx_pop) rx_level_reg <= rx_level_reg - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Avalon master FSM. All bus outputs are registered and only change on
    // a completed transfer (or when leaving IDLE), which keeps them stable
    // for the whole waitrequest stall.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            read        <= 1'b0;
            write       <= 1'b0;
            address     <= ADDR_DATA;
            writedata   <= '0;
            wcred_reg   <= '0;
            last_tx_reg <= 1'b1;   // RX gets the first turn
            burst_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_rx) begin
                        state_reg   <= RX_RD;
                        read        <= 1'b1;
                        address     <= ADDR_DATA;
                        last_tx_reg <= 1'b0;
                    end else if (tx_ok) begin
                        last_tx_reg <= 1'b1;
                        if (wcred_reg != 16'd0) begin
                            state_reg <= TX_WR;
                            write     <= 1'b1;
                            address   <= ADDR_DATA;
                            writedata <= {24'b0, tx_head};
                            burst_reg <= '0;
                        end else begin
                            state_reg <= TX_CHK;
                            read      <= 1'b1;
                            address   <= ADDR_CTRL;
                        end
                    end
                end

                RX_RD: begin
                    // Data is pushed by the FIFO logic when RVALID is set.
                    if (xfer_done) begin
                        read      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end

                TX_CHK: begin
                    // WSPACE = 0 simply leaves wcred at 0; arbitration retries.
                    if (xfer_done) begin
                        read      <= 1'b0;
                        address   <= ADDR_DATA;
                        wcred_reg <= readdata[31:16];
                        state_reg <= IDLE;
                    end
                end

                TX_WR: begin
                    if (xfer_done) begin
                        if (wcred_reg != 16'd0) begin
                            wcred_reg <= wcred_reg - 16'd1;
                        end
                        if (continue_burst) begin
                            writedata <= {24'b0, tx_next_head};
                            burst_reg <= burst_reg + 3'd1;
                        end else begin
                            write     <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    read      <= 1'b0;
                    write     <= 1'b0;
                end
            endcase
        end
    end

`ifdef JTAG_UART_BRIDGE_STATS_EN
    // ------------------------------------------------------------------
    // Traffic statistics
    // ------------------------------------------------------------------
    logic [31:0] tx_cnt_reg;
    logic [31:0] rx_cnt_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_cnt_reg <= '0;
            rx_cnt_reg <= '0;
        end else begin
            if (tx_pop)  tx_cnt_reg <= tx_cnt_reg + 32'd1;
            if (rx_push) rx_cnt_reg <= rx_cnt_reg + 32'd1;
        end
    end

    assign tx_count = tx_cnt_reg;
    assign rx_count = rx_cnt_reg;
`endif

endmodule
